freq_meas_seq: RTL

Synchronous measurement sequencer for the frequency meter. Replaces the toggle-style gate generation with a clocked FSM that generates the counting gate, the counter clear and latch strobes, and range selection. Runs on the system clock and sits between the front-end input conditioning and the BCD counter/latch/display chain. Supports frequency mode (fixed time gate) and period mode (gate spans N input periods).

---
 rtl/freq_meas_pkg.sv | 7 +
 rtl/freq_meas_seq_if.sv | 21 ++
 rtl/freq_meas_seq_edge_sync.sv | 26 ++
 rtl/freq_meas_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared state encoding, range width and decade table for the measurement sequencer.
package freq_meas_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, ARM, GATE, LATCH, EVAL, HOLD} state_t;
    localparam int RANGE_W = 2;
    localparam int DEC_W = 10;
    localparam logic [DEC_W-1:0] DECADE [4] = '{10'd1, 10'd10, 10'd100, 10'd1000};
endpackage

// File: rtl/freq_meas_seq_if.sv
// freq_meas_seq_if: control/status bundle between the sequencer and the counter/latch chain.
interface freq_meas_seq_if;
    import freq_meas_pkg::*;
    logic run;
    logic measure_mode;
    logic [RANGE_W-1:0] range_req;
    logic cnt_ovf;
    logic cnt_low;
    logic gate_en;
    logic cnt_clr;
    logic cnt_latch;
    logic [RANGE_W-1:0] range_sel;
    logic meas_done;
    logic ovf_err;
    logic no_sig;
    logic busy;
    modport master(input run, measure_mode, range_req, cnt_ovf, cnt_low,
                   output gate_en, cnt_clr, cnt_latch, range_sel, meas_done, ovf_err, no_sig, busy);
    modport slave(output run, measure_mode, range_req, cnt_ovf, cnt_low,
                  input gate_en, cnt_clr, cnt_latch, range_sel, meas_done, ovf_err, no_sig, busy);
endinterface

// File: rtl/freq_meas_seq_edge_sync.sv
// edge_sync: SYNC_STAGES-deep synchronizer with a registered rising-edge pulse (latency SYNC_STAGES+1).
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nRst,
    input  logic din,
    output logic rise
);
    logic [SYNC_STAGES:0] sh_q, sh_d;
    logic rise_q, rise_d;
    always_comb begin
        sh_d = {sh_q[SYNC_STAGES-1:0], din};
        rise_d = sh_q[SYNC_STAGES-1] & ~sh_q[SYNC_STAGES];
    end
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sh_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sh_q <= sh_d;
            rise_q <= rise_d;
        end
    end
    assign rise = rise_q;
endmodule

// File: rtl/freq_meas_seq.sv
// freq_meas_seq: clocked gate/clear/latch/range sequencer for the frequency meter.
// Define AUTO_RANGE_EN to enable decade auto-ranging in EVAL; otherwise ranges are manual.
module freq_meas_seq
    import freq_meas_pkg::*;
#(
    parameter int GATE_BASE_CYC = 50000,
    parameter int NUM_RANGES = 4,
    parameter int HOLD_CYC = 25000000,
    parameter int TIMEOUT_CYC = 100000000,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic nRst,
    input logic cpx,
    freq_meas_seq_if.master bus
);
    localparam int PRE_W = $clog2(GATE_BASE_CYC) + 1;
    state_t state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [DEC_W-1:0] dec_q, dec_d;
    logic [31:0] tim_q, tim_d;
    logic [RANGE_W-1:0] range_q, range_d;
    logic mode_q, mode_d, done_q, done_d, ovf_q, ovf_d, nosig_q, nosig_d;
    logic gate_q, clr_q, latch_q, busy_q;
    logic rise, abort, pre_last, dec_last, tmo;
`ifdef AUTO_RANGE_EN
    logic lock_q, lock_d;
`endif
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (.clk(clk), .nRst(nRst), .din(cpx), .rise(rise));
    always_comb begin
        pre_last = pre_q == PRE_W'(GATE_BASE_CYC - 1);
        dec_last = dec_q == DECADE[range_q] - DEC_W'(1);
        tmo = tim_q == 32'(TIMEOUT_CYC - 1);
        abort = state_q != IDLE && state_q != HOLD && (bus.measure_mode != mode_q
`ifndef AUTO_RANGE_EN
                || bus.range_req != range_q
`endif
                );
        state_d = state_q;
        pre_d = '0;
        dec_d = dec_q;
        tim_d = '0;
        range_d = range_q;
        mode_d = mode_q;
        done_d = 1'b0;
        ovf_d = ovf_q;
        nosig_d = nosig_q;
`ifdef AUTO_RANGE_EN
        lock_d = (state_q == IDLE || state_q == HOLD) ? 1'b0 : lock_q;
`endif
        if (abort) state_d = CLEAR;
        else case (state_q)
            IDLE: if (bus.run) begin
                state_d = CLEAR;
                range_d = bus.range_req;
            end
            CLEAR: begin
                state_d = ARM;
                dec_d = '0;
            end
            ARM: if (!mode_q || rise) state_d = GATE;
            else if (tmo) begin
                state_d = HOLD;
                nosig_d = 1'b1;
            end else tim_d = tim_q + 1;
            // frequency gate: prescaler wraps every base period, decade counter counts wraps
            GATE: if (!mode_q) begin
                pre_d = pre_last ? '0 : pre_q + 1'b1;
                if (pre_last) dec_d = dec_q + 1'b1;
                if (pre_last && dec_last) state_d = LATCH;
            end else if (rise) begin
                dec_d = dec_q + 1'b1;
                if (dec_last) state_d = LATCH;
            end else if (tmo) begin
                state_d = HOLD;
                nosig_d = 1'b1;
            end else tim_d = tim_q + 1;
            // range decision is taken here so meas_done/range_sel are valid during EVAL
            LATCH: begin
                state_d = EVAL;
`ifdef AUTO_RANGE_EN
                if (bus.cnt_ovf && range_q != '0) begin
                    range_d = range_q - 1'b1;
                    lock_d = 1'b1;
                end else if (bus.cnt_low && int'(range_q) < NUM_RANGES - 1 && !lock_q)
                    range_d = range_q + 1'b1;
                else
`endif
                begin
                    done_d = 1'b1;
                    ovf_d = bus.cnt_ovf;
                    nosig_d = 1'b0;
                end
            end
            EVAL: state_d = done_q ? HOLD : CLEAR;
            HOLD: if (tim_q == 32'(HOLD_CYC - 1)) state_d = bus.run ? CLEAR : IDLE;
            else tim_d = tim_q + 1;
            default: state_d = IDLE;
        endcase
        if (state_d == CLEAR) begin
            mode_d = bus.measure_mode;
`ifndef AUTO_RANGE_EN
            range_d = bus.range_req;
`endif
        end
    end
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            pre_q <= '0;
            dec_q <= '0;
            tim_q <= '0;
            range_q <= '0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
            nosig_q <= 1'b0;
            gate_q <= 1'b0;
            clr_q <= 1'b0;
            latch_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef AUTO_RANGE_EN
            lock_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pre_q <= pre_d;
            dec_q <= dec_d;
            tim_q <= tim_d;
            range_q <= range_d;
            mode_q <= mode_d;
            done_q <= done_d;
            ovf_q <= ovf_d;
            nosig_q <= nosig_d;
            gate_q <= state_d == GATE;
            clr_q <= state_d == CLEAR;
            latch_q <= state_d == LATCH;
            busy_q <= state_d != IDLE && state_d != HOLD;
`ifdef AUTO_RANGE_EN
            lock_q <= lock_d;
`endif
        end
    end
    assign bus.gate_en = gate_q;
    assign bus.cnt_clr = clr_q;
    assign bus.cnt_latch = latch_q;
    assign bus.range_sel = range_q;
    assign bus.meas_done = done_q;
    assign bus.ovf_err = ovf_q;
    assign bus.no_sig = nosig_q;
    assign bus.busy = busy_q;
endmodule
